sensor_mem_ctl: RTL and testbench

Parametrised single-port synchronous memory with a built-in clear engine, configurable read latency and read-valid signalling. It serves as sample/config storage inside the sensor node datapath. It replaces per-bit reset initialisation with a sequential zero-fill of the array after reset or on request. It flags illegal accesses: out-of-range addresses and accesses while busy.

---
 rtl/sensor_mem_ctl.sv | 135 +++++++++++++
 tb/tb_sensor_mem_ctl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_mem_ctl.sv
// Single-port synchronous sample/config memory with a sequential zero-fill engine,
// 1- or 2-cycle read latency with a read-valid pulse, and a sticky illegal-access flag.
module sensor_mem_ctl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              read,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic              dbg_state
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clearing;
  logic              w_in_range;
  logic              w_acc_ok;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_err_set;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_data;

  // Read and write share one address port, so a simultaneous read+write always
  // targets the same word; the array read below happens before the write lands
  // (read-first), which gives the old contents back.
  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_in_range  = ({1'b0, addr} < DEPTH_EXT);
  assign w_acc_ok    = (r_state == ST_IDLE) && !clr_req;
  assign w_rd_acc    = w_acc_ok && read;
  assign w_wr_acc    = w_acc_ok && write && w_in_range;
  assign w_err_set   = (w_clearing && (read || write)) ||
                       (w_acc_ok && (read || write) && !w_in_range);
  assign w_mem_we    = w_clearing || w_wr_acc;
  assign w_mem_addr  = w_clearing ? r_clr_ptr : addr;
  assign w_mem_wdata = w_clearing ? '0 : data_in;
  assign w_rd_data   = w_in_range ? r_mem[addr] : '0;

  // Array has no reset; the clear engine is what zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == LAST_PTR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          r_clr_ptr <= r_clr_ptr + 1'b1;
        end
        default: begin
          if (clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
          end
        end
      endcase
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_p1_valid;
      logic [DATA_W-1:0] r_p1_data;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p1_valid <= 1'b0;
          r_p1_data  <= '0;
          r_rd_valid <= 1'b0;
          r_data_out <= '0;
        end else begin
          r_p1_valid <= w_rd_acc;
          if (w_rd_acc) r_p1_data <= w_rd_data;
          r_rd_valid <= r_p1_valid;
          if (r_p1_valid) r_data_out <= r_p1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_valid <= 1'b0;
          r_data_out <= '0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_data_out <= w_rd_data;
        end
      end
    end
  endgenerate

  assign data_out  = r_data_out;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sensor_mem_ctl.sv
// Directed bench for sensor_mem_ctl: three instances share stimulus -- A (256 words,
// latency 1), B (256 words, latency 2) and C (200 words, latency 1).
module tb_sensor_mem_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_req = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] a_data_out, b_data_out, c_data_out;
  logic       a_rd_valid, b_rd_valid, c_rd_valid;
  logic       a_busy, b_busy, c_busy;
  logic       a_err, b_err, c_err;
  logic       a_dbg, b_dbg, c_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sensor_mem_ctl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .READ_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .addr(addr), .data_in(data_in),
    .write(write), .read(read), .err_clr(err_clr), .data_out(a_data_out),
    .rd_valid(a_rd_valid), .busy(a_busy), .err(a_err), .dbg_state(a_dbg));

  sensor_mem_ctl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .READ_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .addr(addr), .data_in(data_in),
    .write(write), .read(read), .err_clr(err_clr), .data_out(b_data_out),
    .rd_valid(b_rd_valid), .busy(b_busy), .err(b_err), .dbg_state(b_dbg));

  sensor_mem_ctl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .READ_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .addr(addr), .data_in(data_in),
    .write(write), .read(read), .err_clr(err_clr), .data_out(c_data_out),
    .rd_valid(c_rd_valid), .busy(c_busy), .err(c_err), .dbg_state(c_dbg));

  // One clock of stimulus; returns 1 time unit after the edge so outputs are stable.
  task automatic drive(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic clr, input logic ec);
    read = rd; write = wr; addr = a; data_in = d; clr_req = clr; err_clr = ec;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; clr_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int fa, fc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", a_busy); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", a_rd_valid); end
    n_checks++; if (a_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", a_data_out); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_checks++; if (a_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", a_dbg); end
    rst_n = 1'b1;
    fa = 0; fc = 0;
    for (int n = 1; n <= 600 && (fa == 0 || fc == 0); n++) begin
      @(posedge clk); #1;
      if (!a_busy && fa == 0) fa = n;
      if (!c_busy && fc == 0) fc = n;
    end
    n_checks++; if (fa != 256) begin n_fail++; $display("FAIL clear_len_256: got %0d want 256", fa); end
    n_checks++; if (fc != 200) begin n_fail++; $display("FAIL clear_len_200: got %0d want 200", fc); end
    n_checks++; if (a_dbg !== 1'b1) begin n_fail++; $display("FAIL state_idle: got %b want 1", a_dbg); end
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL lat2_busy_done: got %b want 0", b_busy); end
  endtask

  task automatic test_clear_reads();
    logic [7:0] addrs [3] = '{8'h00, 8'h7F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, addrs[i], 8'h00, 1'b0, 1'b0);
      n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'h00) begin n_fail++; $display("FAIL clear_read_a[%h]: got v=%b d=%h want v=1 d=00", addrs[i], a_rd_valid, a_data_out); end
      n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL lat2_early[%h]: got v=%b want 0", addrs[i], b_rd_valid); end
      idle_cycle();
      n_checks++; if (b_rd_valid !== 1'b1 || b_data_out !== 8'h00) begin n_fail++; $display("FAIL clear_read_b[%h]: got v=%b d=%h want v=1 d=00", addrs[i], b_rd_valid, b_data_out); end
      n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse[%h]: got %b want 0", addrs[i], a_rd_valid); end
    end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_after_reads: got %b want 0", a_err); end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL write_no_resp: got %b want 0", a_rd_valid); end
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=a5", a_rd_valid, a_data_out); end
    n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_lat2_early: got %b want 0", b_rd_valid); end
    idle_cycle();
    n_checks++; if (b_rd_valid !== 1'b1 || b_data_out !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_lat2: got v=%b d=%h want v=1 d=a5", b_rd_valid, b_data_out); end
    n_checks++; if (a_rd_valid !== 1'b0 || a_data_out !== 8'hA5) begin n_fail++; $display("FAIL data_hold: got v=%b d=%h want v=0 d=a5", a_rd_valid, a_data_out); end
  endtask

  task automatic test_rw_same();
    drive(1'b0, 1'b1, 8'h20, 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h20, 8'h99, 1'b0, 1'b0);
    n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'h3C) begin n_fail++; $display("FAIL read_first_a: got v=%b d=%h want v=1 d=3c", a_rd_valid, a_data_out); end
    idle_cycle();
    n_checks++; if (b_data_out !== 8'h3C) begin n_fail++; $display("FAIL read_first_b: got %h want 3c", b_data_out); end
    drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_data_out !== 8'h99) begin n_fail++; $display("FAIL rw_new_a: got %h want 99", a_data_out); end
    idle_cycle();
    n_checks++; if (b_data_out !== 8'h99) begin n_fail++; $display("FAIL rw_new_b: got %h want 99", b_data_out); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rw_err: got %b want 0", a_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_q [$];
    logic [7:0] e;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'h30 + i), vals[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h30 + i), 8'h00, 1'b0, 1'b0);
      n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== vals[i]) begin n_fail++; $display("FAIL b2b_a[%0d]: got v=%b d=%h want v=1 d=%h", i, a_rd_valid, a_data_out, vals[i]); end
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (b_rd_valid !== 1'b1 || b_data_out !== e) begin n_fail++; $display("FAIL b2b_b[%0d]: got v=%b d=%h want v=1 d=%h", i, b_rd_valid, b_data_out, e); end
      end
      exp_q.push_back(vals[i]);
    end
    idle_cycle();
    e = exp_q.pop_front();
    n_checks++; if (b_rd_valid !== 1'b1 || b_data_out !== e) begin n_fail++; $display("FAIL b2b_b_last: got v=%b d=%h want v=1 d=%h", b_rd_valid, b_data_out, e); end
    n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_a_end: got %b want 0", a_rd_valid); end
  endtask

  task automatic test_oob();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL oob_pre_clear: got %b want 0", c_err); end
    drive(1'b0, 1'b1, 8'hC8, 8'h5A, 1'b0, 1'b0);
    n_checks++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL oob_write_err: got %b want 1", c_err); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL inrange_write_err: got %b want 0", a_err); end
    drive(1'b1, 1'b0, 8'hC8, 8'h00, 1'b0, 1'b0);
    n_checks++; if (c_rd_valid !== 1'b1 || c_data_out !== 8'h00) begin n_fail++; $display("FAIL oob_read: got v=%b d=%h want v=1 d=00", c_rd_valid, c_data_out); end
    n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'h5A) begin n_fail++; $display("FAIL inrange_c8: got v=%b d=%h want v=1 d=5a", a_rd_valid, a_data_out); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", c_err); end
    drive(1'b1, 1'b0, 8'hC8, 8'h00, 1'b0, 1'b1);
    n_checks++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", c_err); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hC7, 8'h6B, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'hC7, 8'h00, 1'b0, 1'b0);
    n_checks++; if (c_data_out !== 8'h6B || c_err !== 1'b0) begin n_fail++; $display("FAIL last_addr: got d=%h e=%b want d=6b e=0", c_data_out, c_err); end
  endtask

  task automatic test_busy_access();
    int n;
    for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, 8'(i), 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_data_out !== 8'hFF) begin n_fail++; $display("FAIL fill_read: got %h want ff", a_data_out); end
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0);
    n_checks++; if (a_busy !== 1'b1 || a_dbg !== 1'b0) begin n_fail++; $display("FAIL clr_req_busy: got b=%b s=%b want b=1 s=0", a_busy, a_dbg); end
    n_checks++; if (a_rd_valid !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL clr_req_priority: got v=%b e=%b want v=0 e=0", a_rd_valid, a_err); end
    n_checks++; if (b_rd_valid !== 1'b1 || b_data_out !== 8'hFF) begin n_fail++; $display("FAIL preclear_read: got v=%b d=%h want v=1 d=ff", b_rd_valid, b_data_out); end
    n = 0;
    repeat (4) begin idle_cycle(); n++; end
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    n++;
    n_checks++; if (a_rd_valid !== 1'b0 || a_err !== 1'b1) begin n_fail++; $display("FAIL busy_read: got v=%b e=%b want v=0 e=1", a_rd_valid, a_err); end
    n_checks++; if (a_data_out !== 8'hFF) begin n_fail++; $display("FAIL busy_hold: got %h want ff", a_data_out); end
    while (a_busy && n < 600) begin idle_cycle(); n++; end
    n_checks++; if (n != 256) begin n_fail++; $display("FAIL reclear_len: got %0d want 256", n); end
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 1'b0);
      n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'h00) begin n_fail++; $display("FAIL zero_fill[%h]: got v=%b d=%h want v=1 d=00", i, a_rd_valid, a_data_out); end
    end
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", a_err); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_clr_a: got %b want 0", a_err); end
  endtask

  task automatic test_reset_midclear();
    int n;
    drive(1'b0, 1'b1, 8'h50, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_data_out !== 8'h77) begin n_fail++; $display("FAIL pre_reset_read: got %h want 77", a_data_out); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (99) idle_cycle();
    drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_busy !== 1'b1 || a_err !== 1'b1) begin n_fail++; $display("FAIL midclear_state: got b=%b e=%b want b=1 e=1", a_busy, a_err); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_data_out !== 8'h00 || a_err !== 1'b0 || a_rd_valid !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL async_reset: got d=%h e=%b v=%b b=%b want d=00 e=0 v=0 b=1", a_data_out, a_err, a_rd_valid, a_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (a_busy && n < 600) begin idle_cycle(); n++; end
    n_checks++; if (n != 256) begin n_fail++; $display("FAIL restart_len: got %0d want 256", n); end
    drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    n_checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 8'h00) begin n_fail++; $display("FAIL restart_zero: got v=%b d=%h want v=1 d=00", a_rd_valid, a_data_out); end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_rw_same();
    test_back_to_back();
    test_oob();
    test_busy_access();
    test_reset_midclear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
